// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit serializer: FSM encoding,
// bit-ordering constants and the default word width.
package spi_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam logic ORDER_MSB     = 1'b0;
   localparam logic ORDER_LSB     = 1'b1;
   localparam int   DEFAULT_WIDTH = 16;

endpackage

// File: rtl/spi_bit_select.sv
// WIDTH:1 selector that picks the word bit sitting at transmission
// position cnt for the requested ordering (MSB-first or LSB-first).
module spi_bit_select
   import spi_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] word,
   input  logic [CNT_W-1:0] cnt,
   input  logic             lsb_first,
   output logic             bit_out
);

   localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] idx;

   // Translate transmission position into a word bit position, then select it
   always_comb begin
      idx     = (lsb_first == ORDER_LSB) ? cnt : (TOP_IDX - cnt);
      bit_out = word[idx];
   end

endmodule

// File: rtl/spi_shift_serializer.sv
// Parallel-to-serial shifter for the SPI transmit path. Holds the word,
// the bit counter and the ordering mode; advances one bit per tick and
// accepts a new word either when idle or on the last bit's tick so that
// consecutive words leave the pin with no idle gap.
//
// Load handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high. load_ready is combinational and never depends
// on load_valid; the source may hold load_valid and data_in for as long as
// it likes and only the accepting edge samples data_in and lsb_first.
module spi_shift_serializer
   import spi_pkg::*;
#(
   parameter int   WIDTH    = DEFAULT_WIDTH,
   parameter int   CNT_W    = $clog2(WIDTH),
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             lsb_first,
   input  logic             tick,
   output logic             sdo,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_idx
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_d;
   logic             lsb_q;
   logic             lsb_d;
   logic             sdo_q;
   logic             sdo_d;
   logic             done_q;
   logic             last_tick;
   logic             accept;
   logic             sel_bit;

   // State register; reset aborts any word in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus next counter/word/order; accept wins over returning to idle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      lsb_d   = lsb_q;
      if (accept) begin
         state_d = ST_SHIFT;
         cnt_d   = '0;
         word_d  = data_in;
         lsb_d   = lsb_first;
      end else if (last_tick) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if ((state_q == ST_SHIFT) && tick) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Outputs and handshake; load_ready opens in idle or on the last bit's tick
   always_comb begin
      last_tick  = (state_q == ST_SHIFT) && tick && (cnt_q == LAST_CNT);
      load_ready = !rst && ((state_q == ST_IDLE) || last_tick);
      accept     = load_valid && load_ready;
      busy       = (state_q == ST_SHIFT);
      bit_idx    = cnt_q;
      sdo        = sdo_q;
      done       = done_q;
   end

   // Bit that will be on the pin after this edge, chosen from next-cycle values
   spi_bit_select #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_select (
      .word      (word_d),
      .cnt       (cnt_d),
      .lsb_first (lsb_d),
      .bit_out   (sel_bit)
   );

   assign sdo_d = (state_d == ST_SHIFT) ? sel_bit : IDLE_LVL;

   // Datapath registers: counter, word, order, registered pin and done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         word_q <= '0;
         lsb_q  <= ORDER_MSB;
         sdo_q  <= IDLE_LVL;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
         lsb_q  <= lsb_d;
         sdo_q  <= sdo_d;
         done_q <= last_tick;
      end
   end

endmodule

// File: tb/tb_spi_shift_serializer.sv
// Bench for spi_shift_serializer: a 16-bit MSB/LSB instance driven from a
// vector table and hand sequences, tracked cycle by cycle against a
// reference model with an expected-bit queue, plus an 8-bit instance with
// IDLE_LVL=1 exercised with a continuous tick.
module tb_spi_shift_serializer;

   logic        clk;
   logic        rst;

   logic [15:0] din;
   logic        lv;
   logic        lsb;
   logic        tick;
   logic        ready;
   logic        sdo;
   logic        busy;
   logic        done;
   logic [3:0]  idx;

   logic [7:0]  din8;
   logic        lv8;
   logic        lsb8;
   logic        tick8;
   logic        ready8;
   logic        sdo8;
   logic        busy8;
   logic        done8;
   logic [2:0]  idx8;

   int          errors = 0;
   int          checks = 0;
   logic [0:0]  exp_q[$];

   typedef struct {
      logic [15:0] data;
      logic        lsb;
      int          period;
      logic [15:0] exp_stream;
   } vec_t;

   vec_t vecs[5];

   spi_shift_serializer #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (din),
      .load_valid (lv),
      .load_ready (ready),
      .lsb_first  (lsb),
      .tick       (tick),
      .sdo        (sdo),
      .busy       (busy),
      .done       (done),
      .bit_idx    (idx)
   );

   spi_shift_serializer #(.WIDTH(8), .IDLE_LVL(1'b1)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .data_in    (din8),
      .load_valid (lv8),
      .load_ready (ready8),
      .lsb_first  (lsb8),
      .tick       (tick8),
      .sdo        (sdo8),
      .busy       (busy8),
      .done       (done8),
      .bit_idx    (idx8)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model for the 16-bit instance: inputs sampled mid-cycle,
   // outputs compared one time unit after the following rising edge.
   initial begin : monitor
      logic        s_rst, s_lv, s_tick, s_lsb;
      logic [15:0] s_din;
      logic        exp_ready, last, exp_done, m_busy, m_sdo;
      logic [3:0]  m_cnt;
      m_busy   = 1'b0;
      m_cnt    = 4'd0;
      m_sdo    = 1'b0;
      exp_done = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         s_rst  = rst;
         s_lv   = lv;
         s_tick = tick;
         s_lsb  = lsb;
         s_din  = din;
         exp_ready = !s_rst && (!m_busy || (s_tick && m_cnt == 4'd15));
         check("load_ready", ready, exp_ready);
         last = m_busy && s_tick && (m_cnt == 4'd15);
         @(posedge clk);
         #1;
         if (s_rst) begin
            m_busy   = 1'b0;
            m_cnt    = 4'd0;
            m_sdo    = 1'b0;
            exp_done = 1'b0;
            exp_q.delete();
         end else begin
            exp_done = last;
            if (s_lv && exp_ready) begin
               exp_q.delete();
               for (int k = 0; k < 16; k++) begin
                  exp_q.push_back(s_lsb ? s_din[k] : s_din[15-k]);
               end
               m_busy = 1'b1;
               m_cnt  = 4'd0;
               m_sdo  = exp_q.pop_front();
            end else if (m_busy && s_tick && !last) begin
               m_cnt = m_cnt + 4'd1;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_underflow: got empty queue expected a pending bit");
                  m_sdo = 1'b0;
               end else begin
                  m_sdo = exp_q.pop_front();
               end
            end else if (last) begin
               m_busy = 1'b0;
               m_cnt  = 4'd0;
               m_sdo  = 1'b0;
            end
         end
         check("sdo", sdo, m_sdo);
         check("busy", busy, m_busy);
         check("done", done, exp_done);
         check("bit_idx", idx, m_cnt);
      end
   end

   // Send one word on the 16-bit instance with a tick every `period` cycles,
   // collecting the pin value seen at each tick. With disturb set, a
   // different word and flipped order are offered mid-word while tick is low.
   task automatic run_word(input logic [15:0] d, input logic l, input int period,
                           input logic disturb, output logic [15:0] stream,
                           output int dones, output int rbad);
      int guard;
      stream = '0;
      dones  = 0;
      rbad   = 0;
      guard  = 0;
      @(negedge clk);
      lv   = 1'b1;
      din  = d;
      lsb  = l;
      tick = 1'b0;
      #1;
      while (!ready && guard < 20) begin
         @(negedge clk);
         #1;
         guard++;
      end
      check("load_accept_wait", (guard < 20), 1'b1);
      for (int i = 0; i < 16; i++) begin
         for (int c = 0; c < period - 1; c++) begin
            @(negedge clk);
            tick = 1'b0;
            if (disturb && i >= 4 && i <= 10) begin
               lv  = 1'b1;
               din = ~d;
               lsb = ~lsb;
            end else begin
               lv = 1'b0;
            end
            #1;
            if (done) dones++;
            if (lv && ready) rbad++;
         end
         @(negedge clk);
         lv   = 1'b0;
         tick = 1'b1;
         #1;
         stream = {stream[14:0], sdo};
         if (done) dones++;
      end
      repeat (3) begin
         @(negedge clk);
         tick = 1'b0;
         lv   = 1'b0;
         #1;
         if (done) dones++;
      end
   endtask

   // Watchdog
   initial begin
      #500000;
      errors++;
      checks++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Main sequence
   initial begin
      logic [15:0] stream;
      logic [31:0] stream32;
      logic [7:0]  s8;
      int          dones;
      int          rbad;
      int          busy_low;

      vecs[0] = '{data: 16'hA5C3, lsb: 1'b0, period: 4, exp_stream: 16'hA5C3};
      vecs[1] = '{data: 16'hA5C3, lsb: 1'b1, period: 4, exp_stream: 16'hC3A5};
      vecs[2] = '{data: 16'hA5C3, lsb: 1'b0, period: 1, exp_stream: 16'hA5C3};
      vecs[3] = '{data: 16'h8001, lsb: 1'b1, period: 3, exp_stream: 16'h8001};
      vecs[4] = '{data: 16'h1234, lsb: 1'b1, period: 2, exp_stream: 16'h2C48};

      rst   = 1'b1;
      din   = '0;
      lv    = 1'b0;
      lsb   = 1'b0;
      tick  = 1'b0;
      din8  = '0;
      lv8   = 1'b0;
      lsb8  = 1'b0;
      tick8 = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_sdo", sdo, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_idx", idx, 4'd0);
      check("rst_ready", ready, 1'b0);
      check("rst_sdo8_idle_lvl", sdo8, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      // Vector table: ordering modes and tick spacings
      for (int i = 0; i < 5; i++) begin
         run_word(vecs[i].data, vecs[i].lsb, vecs[i].period, 1'b0, stream, dones, rbad);
         check($sformatf("vec%0d_stream", i), stream, vecs[i].exp_stream);
         check($sformatf("vec%0d_done_count", i), dones, 1);
      end

      // Offered word and toggled order mid-word must not disturb the word in flight
      run_word(16'hA5C3, 1'b0, 4, 1'b1, stream, dones, rbad);
      check("midword_stream", stream, 16'hA5C3);
      check("midword_done_count", dones, 1);
      check("midword_ready_high", rbad, 0);

      // Back-to-back words with load_valid held: no idle cycle between them
      @(negedge clk);
      lv   = 1'b1;
      din  = 16'hFFFF;
      lsb  = 1'b0;
      tick = 1'b0;
      stream32 = '0;
      dones    = 0;
      busy_low = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         tick = 1'b0;
         if (i == 0) din = 16'h0001;
         if (i == 16) lv = 1'b0;
         #1;
         if (done) dones++;
         if (!busy) busy_low++;
         @(negedge clk);
         tick = 1'b1;
         #1;
         stream32 = {stream32[30:0], sdo};
         if (done) dones++;
         if (!busy) busy_low++;
      end
      repeat (3) begin
         @(negedge clk);
         tick = 1'b0;
         lv   = 1'b0;
         #1;
         if (done) dones++;
      end
      check("b2b_stream", stream32, 32'hFFFF_0001);
      check("b2b_done_count", dones, 2);
      check("b2b_busy_low_cycles", busy_low, 0);

      // Reset during bit 5 of 0xA5C3 aborts with no done pulse
      @(negedge clk);
      lv   = 1'b1;
      din  = 16'hA5C3;
      lsb  = 1'b0;
      tick = 1'b0;
      @(negedge clk);
      lv   = 1'b0;
      tick = 1'b1;
      repeat (5) @(negedge clk);
      tick = 1'b0;
      #1;
      check("pre_reset_idx", idx, 4'd5);
      check("pre_reset_sdo", sdo, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_sdo", sdo, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_idx", idx, 4'd0);
      check("abort_ready", ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      dones    = 0;
      busy_low = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         tick = i[0];
         #1;
         if (done) dones++;
         if (busy) busy_low++;
      end
      tick = 1'b0;
      check("abort_no_done", dones, 0);
      check("abort_stays_idle", busy_low, 0);

      // 8-bit instance, IDLE_LVL=1, tick held high: one bit per cycle
      @(negedge clk);
      lv8   = 1'b1;
      din8  = 8'h3C;
      lsb8  = 1'b0;
      tick8 = 1'b1;
      s8       = '0;
      busy_low = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         lv8 = 1'b0;
         #1;
         s8 = {s8[6:0], sdo8};
         if (!busy8) busy_low++;
      end
      @(negedge clk);
      #1;
      check("w8_sdo_after", sdo8, 1'b1);
      check("w8_done_pulse", done8, 1'b1);
      check("w8_busy_after", busy8, 1'b0);
      @(negedge clk);
      tick8 = 1'b0;
      #1;
      check("w8_done_single", done8, 1'b0);
      check("w8_sdo_idle", sdo8, 1'b1);
      check("w8_stream", s8, 8'h3C);
      check("w8_busy_low_cycles", busy_low, 0);

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_shift_serializer.md
Name: spi_shift_serializer

Overview:
- Parametrised parallel-to-serial shifter for the SPI transmit path.
- Replaces the fixed 16:1 bit-select mux and its external bit counter with a single block holding:
  - the word register
  - the bit counter
  - the MSB/LSB-first ordering mode
  - a load handshake
- Sits between the word source (register file / FIFO) and the SPI pin driver.
- Advances one bit per `tick` pulse from the SPI clock divider.

Parameters:
- WIDTH, 16: word width in bits; minimum 2.
- CNT_W, $clog2(WIDTH): bit-counter width.
- IDLE_LVL, 1'b0: level driven on sdo when no word is in flight.

Ports:
- clk, input, 1: single system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- data_in, input, WIDTH: word to transmit; sampled only on load accept.
- load_valid, input, 1: source has a word on data_in.
- load_ready, output, 1: block can accept a word this cycle.
- lsb_first, input, 1: ordering mode (0 = MSB first, 1 = LSB first); sampled on load accept only.
- tick, input, 1: one-cycle shift strobe; advances to the next bit.
- sdo, output, 1: serial data out (registered).
- busy, output, 1: word in flight.
- done, output, 1: one-cycle pulse when the last bit's tick is consumed.
- bit_idx, output, CNT_W: index (0..WIDTH-1) of the bit currently on sdo, in transmission order.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, sdo=IDLE_LVL, busy=0, done=0, bit_idx=0.
  - Word register cleared.
  - load_ready forced 0 while rst is high.
  - Reset mid-word aborts immediately; no done pulse.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1; tick ignored; sdo=IDLE_LVL.
  - Accept (load_valid & load_ready) at edge N: capture data_in and lsb_first; cnt=0; state=SHIFT; busy=1 from N+1.
  - sdo shows the first bit from N+1: data_in[WIDTH-1] if MSB-first, data_in[0] if LSB-first.
- Bit selection: sdo = word[WIDTH-1-cnt] (MSB-first) or word[cnt] (LSB-first). bit_idx = cnt.
- SHIFT, tick=1 and cnt<WIDTH-1: cnt+1; sdo updates at the same edge. No wrap inside a word.
- SHIFT, tick=1 and cnt==WIDTH-1 (last bit):
  - done=1 for exactly the following cycle.
  - load_ready=1 combinationally in this cycle (back-to-back support).
  - If load_valid=1 in the same cycle: new word captured; cnt=0; stay in SHIFT; busy stays 1; sdo = first bit of the new word, with no idle gap.
  - Otherwise: state=IDLE, busy=0, sdo=IDLE_LVL, cnt=0.
- SHIFT, tick=0: hold everything. load_ready=0; load_valid is ignored (no capture).
- load_ready is combinational: (state==IDLE) | (state==SHIFT & tick & cnt==WIDTH-1), gated by !rst.
- data_in and lsb_first changes while busy have no effect on the word in flight.
- tick held high for several cycles: one bit per cycle (legal, divider-free mode).

Decomposition:
- Shared package spi_pkg holds:
  - state encoding (ST_IDLE, ST_SHIFT)
  - ORDER_MSB / ORDER_LSB constants
  - default WIDTH
- One natural sub-module: spi_bit_select, a parametrised WIDTH:1 combinational selector taking word, cnt and lsb_first and returning the bit.
- FSM, counter and handshake stay in the top module.

Test Plan:
- Reset with sdo forced mid-word: assert rst during bit 5 of 0xA5C3 → next cycle sdo=0, busy=0, done=0, bit_idx=0, no done pulse afterwards.
- MSB-first 0xA5C3, WIDTH=16, tick every 4th cycle → sdo sequence 1010_0101_1100_0011; done pulses once, one cycle after the 16th tick; busy falls with done.
- LSB-first 0xA5C3 → sdo sequence 1100_0011_1010_0101; bit_idx 0..15 in step.
- Back-to-back: hold load_valid with 0xFFFF then 0x0001 (MSB-first) → no IDLE_LVL cycle between words; busy stays 1 for 32 ticks; done pulses twice.
- Load during mid-word tick=0 with load_valid=1 → load_ready=0, data_in not captured, in-flight word unaffected; lsb_first toggled mid-word has no effect.
- Continuous tick=1, WIDTH=8, IDLE_LVL=1, word 0x3C → sdo 00111100 on 8 consecutive cycles, then returns to 1.
